a51_keystream_engine: RTL and testbench

A51_KEYSTREAM_ENGINE -- requirements
Module: a51_keystream_engine

---
 rtl/a51_pkg.sv | 30 +++
 rtl/a51_lfsr.sv | 41 ++++
 rtl/a51_keystream_engine.sv | 110 +++++++++++
 tb/tb_a51_keystream_engine.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/a51_pkg.sv
// Shared constants for the A5/1 keystream engine: register geometry, clocking taps,
// phase lengths and the sequencer state encoding.
package a51_pkg;

  localparam int R1_W = 19;
  localparam int R2_W = 22;
  localparam int R3_W = 23;

  localparam logic [R1_W-1:0] R1_TAPS = 19'h7_2000;   // bits 18,17,16,13
  localparam logic [R2_W-1:0] R2_TAPS = 22'h30_0000;  // bits 21,20
  localparam logic [R3_W-1:0] R3_TAPS = 23'h70_0080;  // bits 22,21,20,7

  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  localparam int KEY_LEN   = 64;
  localparam int FRAME_LEN = 22;
  localparam int MIX_LEN   = 100;
  localparam int OUT_LEN   = 228;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_KEYLOAD   = 3'd1,
    ST_FRAMELOAD = 3'd2,
    ST_MIX       = 3'd3,
    ST_OUT       = 3'd4
  } a51_state_e;

endpackage

// File: rtl/a51_lfsr.sv
// One A5/1 shift register: shifts toward the MSB with tap parity (plus load bit) into bit 0.
// clear zeroes the register before the same cycle's shift; msb_next is the MSB after this cycle.
module a51_lfsr
  import a51_pkg::*;
#(
  parameter int              WIDTH   = R1_W,
  parameter logic [WIDTH-1:0] TAPS   = R1_TAPS,
  parameter int              CLK_BIT = R1_CLK
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic shift_en,
  input  logic load_bit,
  output logic clk_tap,
  output logic msb_next
);

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] nxt;

  always_comb begin
    // NOTE: every variable gets its value on every path, so no latch is inferred.
    base = clear ? '0 : r;
    nxt  = {base[WIDTH-2:0], (^(base & TAPS)) ^ load_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for all clocked state avoid ordering races between blocks.
    if (!rst_n) begin
      r <= '0;
    end else if (shift_en) begin
      r <= nxt;
    end
  end

  assign clk_tap  = r[CLK_BIT];
  assign msb_next = shift_en ? nxt[WIDTH-1] : r[WIDTH-1];

endmodule

// File: rtl/a51_keystream_engine.sv
// A5/1 keystream engine driven by phase strobes; illegal strobe patterns freeze and flag SEQERR.
// Build option A51_CIPHER_XOR_EN: DOUT = DATAIN ^ keystream (otherwise DOUT mirrors KS).
module a51_keystream_engine
  import a51_pkg::*;
(
  input  logic C,
  input  logic CLR_N,
  input  logic ENABLE,
  input  logic STAGEONE,
  input  logic STAGETWO,
  input  logic STAGETHREE,
  input  logic OUTPUTSTAGE,
  input  logic KEYBIT,
  input  logic FRAMEBIT,
  input  logic DATAIN,
  output logic KS,
  output logic DOUT,
  output logic DVALID,
  output logic SEQERR
);

  a51_state_e state, state_next;
  logic [3:0] strobes, legal;
  logic       err, go, restart, load, mix, emit, load_bit, maj;
  logic       cb1, cb2, cb3, msb1, msb2, msb3, sh1, sh2, sh3;
  logic       ks_next, dout_next;

  assign strobes = {OUTPUTSTAGE, STAGETHREE, STAGETWO, STAGEONE};

  // Each state accepts its own strobe (hold) and the next phase's strobe (advance).
  always_comb begin
    legal      = 4'b0001;
    state_next = state;
    case (state)
      ST_IDLE:      legal = 4'b0001;
      ST_KEYLOAD:   legal = 4'b0011;
      ST_FRAMELOAD: legal = 4'b0110;
      ST_MIX:       legal = 4'b1100;
      ST_OUT:       legal = 4'b1001;
      default:      legal = 4'b0001;
    endcase
    if (STAGEONE)         state_next = ST_KEYLOAD;
    else if (STAGETWO)    state_next = ST_FRAMELOAD;
    else if (STAGETHREE)  state_next = ST_MIX;
    else if (OUTPUTSTAGE) state_next = ST_OUT;
  end

  assign err     = ENABLE && (!$onehot0(strobes) || ((strobes & ~legal) != 4'b0000));
  assign go      = ENABLE && (strobes != 4'b0000) && !err;
  assign restart = go && STAGEONE && ((state == ST_IDLE) || (state == ST_OUT));
  assign load    = go && (STAGEONE || STAGETWO);
  assign mix     = go && (STAGETHREE || OUTPUTSTAGE);
  assign emit    = go && OUTPUTSTAGE;

  assign load_bit = load && (STAGEONE ? KEYBIT : FRAMEBIT);
  assign maj      = (cb1 & cb2) | (cb1 & cb3) | (cb2 & cb3);
  assign sh1      = load || (mix && (cb1 == maj));
  assign sh2      = load || (mix && (cb2 == maj));
  assign sh3      = load || (mix && (cb3 == maj));
  assign ks_next  = msb1 ^ msb2 ^ msb3;

  a51_lfsr #(.WIDTH(R1_W), .TAPS(R1_TAPS), .CLK_BIT(R1_CLK)) u_r1 (
    .clk(C), .rst_n(CLR_N), .clear(restart), .shift_en(sh1), .load_bit(load_bit),
    .clk_tap(cb1), .msb_next(msb1)
  );

  a51_lfsr #(.WIDTH(R2_W), .TAPS(R2_TAPS), .CLK_BIT(R2_CLK)) u_r2 (
    .clk(C), .rst_n(CLR_N), .clear(restart), .shift_en(sh2), .load_bit(load_bit),
    .clk_tap(cb2), .msb_next(msb2)
  );

  a51_lfsr #(.WIDTH(R3_W), .TAPS(R3_TAPS), .CLK_BIT(R3_CLK)) u_r3 (
    .clk(C), .rst_n(CLR_N), .clear(restart), .shift_en(sh3), .load_bit(load_bit),
    .clk_tap(cb3), .msb_next(msb3)
  );

`ifdef A51_CIPHER_XOR_EN
  assign dout_next = DATAIN ^ ks_next;
`else
  logic unused_datain;
  assign unused_datain = DATAIN;
  assign dout_next     = ks_next;
`endif

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state  <= ST_IDLE;
      KS     <= 1'b0;
      DOUT   <= 1'b0;
      DVALID <= 1'b0;
      SEQERR <= 1'b0;
    end else begin
      DVALID <= emit;
      if (go) begin
        state <= state_next;
      end
      if (emit) begin
        KS   <= ks_next;
        DOUT <= dout_next;
      end
      // A fresh frame start is the only non-reset way to clear the sticky flag.
      if (err) begin
        SEQERR <= 1'b1;
      end else if (restart) begin
        SEQERR <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_a51_keystream_engine.sv
// Self-checking bench for a51_keystream_engine: algorithmic A5/1 model checked every cycle,
// pinned by the published 114-bit reference keystream.
module tb_a51_keystream_engine;

  logic C = 1'b0;
  logic CLR_N, ENABLE, STAGEONE, STAGETWO, STAGETHREE, OUTPUTSTAGE;
  logic KEYBIT, FRAMEBIT, DATAIN;
  logic KS, DOUT, DVALID, SEQERR;

  a51_keystream_engine dut (
    .C(C), .CLR_N(CLR_N), .ENABLE(ENABLE),
    .STAGEONE(STAGEONE), .STAGETWO(STAGETWO), .STAGETHREE(STAGETHREE), .OUTPUTSTAGE(OUTPUTSTAGE),
    .KEYBIT(KEYBIT), .FRAMEBIT(FRAMEBIT), .DATAIN(DATAIN),
    .KS(KS), .DOUT(DOUT), .DVALID(DVALID), .SEQERR(SEQERR)
  );

  always #5 C = ~C;

  int checks = 0;
  int failures = 0;

  // Reference model state: phase 0..4 = idle, key, frame, mix, out.
  int          m_phase;
  logic [31:0] m_r1, m_r2, m_r3;
  logic        m_ks, m_dout, m_dv, m_err;

  logic dut_q[$];
  logic m_q[$];
  int   dout_ok;
  int   gap_mode;
  int   gap_ctr;
  int   din_mode;

  logic [119:0] ref_vec   = 120'h534EAA582FE8151AB6E1855A728C00;
  logic [63:0]  ref_key   = 64'h1223456789ABCDEF;
  logic [21:0]  ref_frame = 22'h134;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] clk_reg(input logic [31:0] r, input int w,
                                          input logic [31:0] taps, input logic in_bit);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return ((r << 1) & mask) | {31'd0, (^(r & taps)) ^ in_bit};
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_r1 = '0; m_r2 = '0; m_r3 = '0;
    m_ks = 1'b0; m_dout = 1'b0; m_dv = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic [3:0] st, input logic kb,
                            input logic fb, input logic din);
    int   n, k, votes;
    logic b;
    m_dv = 1'b0;
    if (!en || st == 4'b0000) return;
    n = $countones(st);
    k = 0;
    for (int i = 0; i < 4; i++) if (st[i]) k = i + 1;
    if (n > 1 || !(k == m_phase || k == m_phase + 1 || (m_phase == 4 && k == 1))) begin
      m_err = 1'b1;
      return;
    end
    if (k == 1 && (m_phase == 0 || m_phase == 4)) begin
      m_r1 = '0; m_r2 = '0; m_r3 = '0;
      m_err = 1'b0;
    end
    if (k <= 2) begin
      b = (k == 1) ? kb : fb;
      m_r1 = clk_reg(m_r1, 19, 32'h0007_2000, b);
      m_r2 = clk_reg(m_r2, 22, 32'h0030_0000, b);
      m_r3 = clk_reg(m_r3, 23, 32'h0070_0080, b);
    end else begin
      votes = int'(m_r1[8]) + int'(m_r2[10]) + int'(m_r3[10]);
      b = (votes >= 2);
      if (m_r1[8] == b)  m_r1 = clk_reg(m_r1, 19, 32'h0007_2000, 1'b0);
      if (m_r2[10] == b) m_r2 = clk_reg(m_r2, 22, 32'h0030_0000, 1'b0);
      if (m_r3[10] == b) m_r3 = clk_reg(m_r3, 23, 32'h0070_0080, 1'b0);
      if (k == 4) begin
        m_ks = m_r1[18] ^ m_r2[21] ^ m_r3[22];
`ifdef A51_CIPHER_XOR_EN
        m_dout = m_ks ^ din;
`else
        m_dout = m_ks;
`endif
        m_dv = 1'b1;
        m_q.push_back(m_ks);
      end
    end
    m_phase = k;
  endtask

  task automatic compare();
    check("dvalid", 128'(DVALID), 128'(m_dv));
    check("seqerr", 128'(SEQERR), 128'(m_err));
    check("ks", 128'(KS), 128'(m_ks));
    check("dout", 128'(DOUT), 128'(m_dout));
    if (DVALID === 1'b1) begin
      dut_q.push_back(KS);
`ifdef A51_CIPHER_XOR_EN
      if (DOUT === (KS ^ DATAIN)) dout_ok++;
`else
      if (DOUT === KS) dout_ok++;
`endif
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, compare just after the edge.
  task automatic cycle(input logic en, input logic [3:0] st, input logic kb, input logic fb);
    logic din;
    din = (din_mode == 1) ? 1'b1 : 1'($urandom_range(1));
    ENABLE = en;
    {OUTPUTSTAGE, STAGETHREE, STAGETWO, STAGEONE} = st;
    KEYBIT = kb; FRAMEBIT = fb; DATAIN = din;
    @(posedge C);
    model_step(en, st, kb, fb, din);
    #1;
    compare();
  endtask

  task automatic op(input logic [3:0] st, input logic kb, input logic fb);
    if (gap_mode == 1) begin
      if (gap_ctr % 3 == 2) begin
        gap_ctr++;
        cycle(1'b0, st, 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
      gap_ctr++;
    end else if (gap_mode == 2) begin
      while ($urandom_range(3) == 0)
        cycle(1'b0, 4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      if ($urandom_range(7) == 0)
        cycle(1'b1, 4'b0000, 1'($urandom_range(1)), 1'($urandom_range(1)));
      if ($urandom_range(63) == 0)
        cycle(1'b1, 4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    cycle(1'b1, st, kb, fb);
  endtask

  task automatic run_frame(input logic [63:0] key, input logic [21:0] frame,
                           input int n_out, input int err_at);
    dut_q.delete();
    m_q.delete();
    dout_ok = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == err_at) op(4'b0101, 1'($urandom_range(1)), 1'($urandom_range(1)));
      op(4'b0001, key[56 - 8 * (i / 8) + (i % 8)], 1'($urandom_range(1)));
    end
    for (int i = 0; i < 22; i++)  op(4'b0010, 1'($urandom_range(1)), frame[i]);
    for (int i = 0; i < 100; i++) op(4'b0100, 1'($urandom_range(1)), 1'($urandom_range(1)));
    for (int i = 0; i < n_out; i++) op(4'b1000, 1'($urandom_range(1)), 1'($urandom_range(1)));
  endtask

  task automatic check_vector(input string tag);
    logic [113:0] act, mdl, exp;
    act = '0; mdl = '0;
    exp = ref_vec[119:6];
    for (int i = 0; i < 114; i++) begin
      if (i < dut_q.size()) act[113 - i] = dut_q[i];
      if (i < m_q.size())   mdl[113 - i] = m_q[i];
    end
    check({tag, "_dut_stream"}, 128'(act), 128'(exp));
    check({tag, "_model_stream"}, 128'(mdl), 128'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    CLR_N = 1'b0; ENABLE = 1'b0;
    {OUTPUTSTAGE, STAGETHREE, STAGETWO, STAGEONE} = 4'b0000;
    KEYBIT = 1'b0; FRAMEBIT = 1'b0; DATAIN = 1'b0;
    gap_mode = 0; gap_ctr = 0; din_mode = 0; dout_ok = 0;
    model_reset();
    #2;
    check("reset_ks", 128'(KS), 128'(0));
    check("reset_dout", 128'(DOUT), 128'(0));
    check("reset_dvalid", 128'(DVALID), 128'(0));
    check("reset_seqerr", 128'(SEQERR), 128'(0));
    #1 CLR_N = 1'b1;

    // Reference frame, full 228 output bits.
    run_frame(ref_key, ref_frame, 228, -1);
    check_vector("vec_a");
    check("vec_a_count", 128'(dut_q.size()), 128'(228));

    // STAGEONE from OUT restarts; ENABLE low every third cycle; DATAIN held high.
    gap_mode = 1; gap_ctr = 0; din_mode = 1;
    run_frame(ref_key, ref_frame, 114, -1);
    check_vector("vec_gap");
    check("gap_dvalid_count", 128'(dut_q.size()), 128'(114));
    check("dout_relation", 128'(dout_ok), 128'(114));

    // STAGEONE+STAGETHREE during key load: frozen cycle, sticky flag, stream unchanged.
    gap_mode = 0; din_mode = 0;
    run_frame(ref_key, ref_frame, 114, 10);
    check_vector("vec_err");
    check("seqerr_sticky", 128'(SEQERR), 128'(1));

    // Fresh STAGEONE from OUT clears the flag; then reset mid-output.
    run_frame(ref_key, ref_frame, 50, -1);
    check("seqerr_cleared", 128'(SEQERR), 128'(0));
    #2 CLR_N = 1'b0;
    #1;
    model_reset();
    check("midrst_ks", 128'(KS), 128'(0));
    check("midrst_dout", 128'(DOUT), 128'(0));
    check("midrst_dvalid", 128'(DVALID), 128'(0));
    CLR_N = 1'b1;
    // In IDLE an OUTPUTSTAGE strobe is illegal, so the flag must rise.
    cycle(1'b1, 4'b1000, 1'b0, 1'b0);
    check("idle_after_reset", 128'(SEQERR), 128'(1));
    #2 CLR_N = 1'b0;
    #1;
    model_reset();
    check("rst_clears_seqerr", 128'(SEQERR), 128'(0));
    CLR_N = 1'b1;
    run_frame(ref_key, ref_frame, 114, -1);
    check_vector("vec_rerun");

    // Randomised keys/frames with random stalls, idle cycles and stray strobes.
    gap_mode = 2;
    for (int t = 0; t < 3; t++)
      run_frame({$urandom, $urandom}, 22'($urandom), 228, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
